alu_exec_pipeline: RTL and testbench

ALU_EXEC_PIPELINE -- requirements
Module: alu_exec_pipeline

---
 rtl/alu_exec_if.sv | 27 ++
 rtl/alu_exec_pipeline.sv | 194 +++++++++++++++++++
 tb/tb_alu_exec_pipeline.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Request/response bundle for the ALU execute stage.
// Master drives the operation request; slave returns the registered result.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [4:0]      funct;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;
  logic            busy;

  modport master (
    output in_valid, alu_op, funct, a, b,
    input  in_ready, out_valid, result, zero, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, funct, a, b,
    output in_ready, out_valid, result, zero, illegal, busy
  );
endinterface

// File: rtl/alu_exec_pipeline.sv
// Single-issue ALU execute stage with registered outputs and an
// iterative shift-add multiplier (one step per cycle).
module alu_exec_pipeline #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic       clk,
  input logic       reset,
  alu_exec_if.slave io
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT,
    OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_MUL
  } op_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic            out_valid_q, out_valid_d;

  op_t             op;
  logic            ill;
  logic [2:0]      f3;
  logic            f7_5;
  logic            f7_0;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] acc_step;
  logic            take;

  function automatic op_t base_op(
    input logic [2:0] fn3,
    input logic       alt
  );
    op_t r;
    r = OP_ADD;
    unique case (fn3)
      3'b000: if (alt) r = OP_SUB;
      3'b001: r = OP_SLL;
      3'b010: r = OP_SLT;
      3'b011: r = OP_SLTU;
      3'b100: r = OP_XOR;
      3'b101: if (alt) r = OP_SRA;
              else r = OP_SRL;
      3'b110: r = OP_OR;
      default: r = OP_AND;
    endcase
    return r;
  endfunction

  assign f3    = io.funct[2:0];
  assign f7_5  = io.funct[3];
  assign f7_0  = io.funct[4];
  assign shamt = io.b[SHW-1:0];

  always_comb begin
    op  = OP_ADD;
    ill = 1'b0;
    unique case (1'b1)
      (io.alu_op == 2'b00): op = OP_ADD;
      (io.alu_op == 2'b01): op = OP_SUB;
      (io.alu_op == 2'b10): begin
        if (f7_0) begin
          if (f3 == 3'b000 && !f7_5 && MUL_EN)
            op = OP_MUL;
          else
            ill = 1'b1;
        end else if (f7_5 && f3 != 3'b000
                     && f3 != 3'b101) begin
          ill = 1'b1;
        end else begin
          op = base_op(f3, f7_5);
        end
      end
      default: begin
        // I-type: only the shift-right variant honours f7_5
        if (f3 == 3'b001 && f7_5)
          ill = 1'b1;
        else
          op = base_op(f3, f7_5 && f3 == 3'b101);
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADD:  alu_res = io.a + io.b;
      OP_SUB:  alu_res = io.a - io.b;
      OP_SLL:  alu_res = io.a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                          $signed(io.a) < $signed(io.b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, io.a < io.b};
      OP_XOR:  alu_res = io.a ^ io.b;
      OP_SRL:  alu_res = io.a >> shamt;
      OP_SRA:  alu_res = $signed(io.a) >>> shamt;
      OP_OR:   alu_res = io.a | io.b;
      OP_AND:  alu_res = io.a & io.b;
      default: alu_res = '0;
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign take     = io.in_valid && io.in_ready;

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          if (!ill && op == OP_MUL) begin
            mcand_d  = io.a;
            mplier_d = io.b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d    = ill ? '0 : alu_res;
            zero_d      = ill || (alu_res == '0);
            illegal_d   = ill;
            out_valid_d = 1'b1;
          end
        end
      end
      default: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          result_d    = acc_step;
          zero_d      = (acc_step == '0);
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready  = (state_q == S_IDLE) && !reset;
  assign io.busy      = (state_q == S_MUL);
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.zero      = zero_q;
  assign io.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_pipeline.sv
// Bench for alu_exec_pipeline: directed table, multi-cycle sequences
// and random vectors against an arithmetic reference model.
module tb_alu_exec_pipeline;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_exec_if #(.XLEN(32)) bus ();
  alu_exec_if #(.XLEN(8))  bus8 ();

  alu_exec_pipeline #(.XLEN(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .io(bus)
  );
  alu_exec_pipeline #(.XLEN(8), .MUL_EN(1'b0)) dut8 (
    .clk(clk), .reset(reset), .io(bus8)
  );

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        il;
  } vec_t;

  vec_t vt[15];

  function automatic void chk(input string n,
                              input logic [63:0] got,
                              input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, got, exp);
    end
  endfunction

  function automatic void model(
    input logic [1:0] op, input logic [4:0] f,
    input longint unsigned a, input longint unsigned b,
    input int xlen, input bit mul_en,
    output bit ill, output bit is_mul,
    output longint unsigned res);
    longint unsigned mask;
    longint sa, sb;
    int sh;
    mask = (64'd1 << xlen) - 64'd1;
    sa = $signed(a << (64 - xlen)) >>> (64 - xlen);
    sb = $signed(b << (64 - xlen)) >>> (64 - xlen);
    sh = int'(b % longint'(xlen));
    ill = 0;
    is_mul = 0;
    res = 0;
    if (op == 2'b00) res = a + b;
    else if (op == 2'b01) res = a - b;
    else if (op == 2'b10 && f[4]) begin
      if (f[2:0] == 0 && !f[3] && mul_en) begin
        is_mul = 1;
        res = a * b;
      end else ill = 1;
    end
    else if (op == 2'b10 && f[3] && f[2:0] != 0 && f[2:0] != 5)
      ill = 1;
    else if (op == 2'b11 && f[2:0] == 1 && f[3])
      ill = 1;
    else begin
      case (f[2:0])
        3'd0: res = (op == 2'b10 && f[3]) ? a - b : a + b;
        3'd1: res = a << sh;
        3'd2: res = (sa < sb) ? 1 : 0;
        3'd3: res = (a < b) ? 1 : 0;
        3'd4: res = a ^ b;
        3'd5: res = f[3] ? longint'(sa >>> sh) : a >> sh;
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end
    res &= mask;
  endfunction

  task automatic drv(input logic [1:0] op, input logic [4:0] f,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic v);
    bus.alu_op = op;
    bus.funct = f;
    bus.a = a;
    bus.b = b;
    bus.in_valid = v;
  endtask

  task automatic drv8(input logic [1:0] op, input logic [4:0] f,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic v);
    bus8.alu_op = op;
    bus8.funct = f;
    bus8.a = a;
    bus8.b = b;
    bus8.in_valid = v;
  endtask

  initial begin
    int w, busy_n, seen;
    bit il, im;
    longint unsigned er;
    logic [1:0] op;
    logic [4:0] f;
    logic [31:0] a, b;

    vt[0]  = '{2'b10, 5'b01000, 32'h5, 32'h7, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[1]  = '{2'b11, 5'b01101, 32'h80000000, 32'h404, 32'hF8000000, 1'b0, 1'b0};
    vt[2]  = '{2'b11, 5'b00101, 32'h80000000, 32'h404, 32'h08000000, 1'b0, 1'b0};
    vt[3]  = '{2'b01, 5'b00000, 32'h55, 32'h55, 32'h0, 1'b1, 1'b0};
    vt[4]  = '{2'b10, 5'b01110, 32'h1, 32'h2, 32'h0, 1'b1, 1'b1};
    vt[5]  = '{2'b10, 5'b00010, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0};
    vt[6]  = '{2'b10, 5'b00011, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0};
    vt[7]  = '{2'b10, 5'b00001, 32'h1, 32'h21, 32'h2, 1'b0, 1'b0};
    vt[8]  = '{2'b11, 5'b01001, 32'h1, 32'h1, 32'h0, 1'b1, 1'b1};
    vt[9]  = '{2'b10, 5'b10001, 32'h1, 32'h1, 32'h0, 1'b1, 1'b1};
    vt[10] = '{2'b11, 5'b11000, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0};
    vt[11] = '{2'b00, 5'b11111, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0};
    vt[12] = '{2'b10, 5'b11000, 32'h3, 32'h3, 32'h0, 1'b1, 1'b1};
    vt[13] = '{2'b10, 5'b00111, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0};
    vt[14] = '{2'b11, 5'b00100, 32'hFF, 32'h0F, 32'hF0, 1'b0, 1'b0};

    // reset, with a request held high that must not transfer
    reset = 1'b1;
    drv(2'b00, 5'b0, 32'd3, 32'd4, 1'b1);
    drv8(2'b00, 5'b0, 8'd0, 8'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ov", 64'(bus.out_valid), 64'd0);
    chk("rst_res", 64'(bus.result), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd0);
    chk("rst_ill", 64'(bus.illegal), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rdy", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_rdy", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("post_rst_ov", 64'(bus.out_valid), 64'd0);

    // directed table, issued back to back
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drv(vt[i].op, vt[i].f, vt[i].a, vt[i].b, 1'b1);
      chk($sformatf("vec%0d_rdy", i), 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ov", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("vec%0d_res", i), 64'(bus.result), 64'(vt[i].res));
      chk($sformatf("vec%0d_z", i), 64'(bus.zero), 64'(vt[i].z));
      chk($sformatf("vec%0d_il", i), 64'(bus.illegal), 64'(vt[i].il));
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("tbl_ov_drop", 64'(bus.out_valid), 64'd0);

    // MUL with ignored requests while iterating
    @(negedge clk);
    drv(2'b10, 5'b10000, 32'h12345, 32'h100, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("mul_busy0", 64'(bus.busy), 64'd1);
    chk("mul_ov0", 64'(bus.out_valid), 64'd0);
    w = 0;
    busy_n = 0;
    while (!bus.out_valid && w < 40) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      chk("mul_rdy_low", 64'(bus.in_ready), 64'd0);
      drv(2'b00, 5'b0, 32'd1, 32'd1, w[0]);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      w++;
    end
    chk("mul_latency", 64'(w), 64'd32);
    chk("mul_busy_cyc", 64'(busy_n), 64'd32);
    chk("mul_res", 64'(bus.result), 64'h01234500);
    chk("mul_zero", 64'(bus.zero), 64'd0);
    chk("mul_ill", 64'(bus.illegal), 64'd0);
    chk("mul_busy_end", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("mul_done_rdy", 64'(bus.in_ready), 64'd1);
    drv(2'b00, 5'b0, 32'd3, 32'd4, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("after_mul_ov", 64'(bus.out_valid), 64'd1);
    chk("after_mul_res", 64'(bus.result), 64'd7);
    @(posedge clk);
    #1;
    chk("hold_ov", 64'(bus.out_valid), 64'd0);
    chk("hold_res", 64'(bus.result), 64'd7);

    // reset in the middle of a MUL
    @(negedge clk);
    drv(2'b10, 5'b10000, 32'd3, 32'd5, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_ov", 64'(bus.out_valid), 64'd0);
    chk("abort_res", 64'(bus.result), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_rdy", 64'(bus.in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("abort_no_ov", 64'(seen), 64'd0);
    @(negedge clk);
    drv(2'b10, 5'b00000, 32'd3, 32'd4, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("abort_add_ov", 64'(bus.out_valid), 64'd1);
    chk("abort_add_res", 64'(bus.result), 64'd7);

    // 8-bit instance without multiplier
    @(negedge clk);
    drv8(2'b10, 5'b10000, 8'd3, 8'd5, 1'b1);
    @(posedge clk);
    #1;
    chk("m8_ov", 64'(bus8.out_valid), 64'd1);
    chk("m8_ill", 64'(bus8.illegal), 64'd1);
    chk("m8_res", 64'(bus8.result), 64'd0);
    chk("m8_zero", 64'(bus8.zero), 64'd1);
    @(negedge clk);
    drv8(2'b00, 5'b0, 8'hFF, 8'h02, 1'b1);
    @(posedge clk);
    #1;
    chk("m8_ld_res", 64'(bus8.result), 64'h01);
    chk("m8_ld_ill", 64'(bus8.illegal), 64'd0);
    for (int i = 0; i < 100; i++) begin
      op = 2'($urandom);
      f = 5'($urandom);
      a = 32'($urandom_range(0, 255));
      b = 32'($urandom_range(0, 255));
      model(op, f, 64'(a), 64'(b), 8, 1'b0, il, im, er);
      @(negedge clk);
      drv8(op, f, a[7:0], b[7:0], 1'b1);
      @(posedge clk);
      #1;
      chk("r8_ov", 64'(bus8.out_valid), 64'd1);
      chk("r8_res", 64'(bus8.result), er);
      chk("r8_ill", 64'(bus8.illegal), 64'(il));
      chk("r8_zero", 64'(bus8.zero), 64'(er == 0));
    end
    bus8.in_valid = 1'b0;

    // random 32-bit traffic including multiplies
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom);
      f = 5'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40))
                                      : $urandom;
      if ($urandom_range(0, 7) == 0) begin
        op = 2'b10;
        f = 5'b10000;
      end
      model(op, f, 64'(a), 64'(b), 32, 1'b1, il, im, er);
      @(negedge clk);
      drv(op, f, a, b, 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (im) begin
        w = 0;
        while (!bus.out_valid && w < 40) begin
          @(posedge clk);
          #1;
          w++;
        end
        chk("rnd_mul_lat", 64'(w), 64'd32);
      end
      chk("rnd_ov", 64'(bus.out_valid), 64'd1);
      chk("rnd_res", 64'(bus.result), er);
      chk("rnd_ill", 64'(bus.illegal), 64'(il));
      chk("rnd_zero", 64'(bus.zero), 64'(er == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
